mem_stage_ctrl: RTL and testbench

Sequences data-memory accesses issued from the EX/MEM pipeline register into a variable-latency data memory with a req/ready handshake. Stalls the pipeline while an access is in flight. Returns load data to the MEM/WB path. Flags misaligned and timed-out accesses. Sits between the EX/MEM register outputs and the data memory port.

---
 rtl/mem_stage_ctrl.sv | 108 ++++++++++
 tb/tb_mem_stage_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access sequencer: issues req/ready data-memory accesses from EX/MEM,
// stalls the pipeline while one is in flight and flags misaligned or timed-out accesses.
module mem_stage_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        m2reg_mem,
   input  logic        wmem_mem,
   input  logic [31:0] Alu_Result_mem,
   input  logic [31:0] rb_mem,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        stall_pipe,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misalign_exc,
   output logic        bus_err
);

   typedef enum logic [2:0] {IDLE, ACCESS, DONE, EXC, ERR} state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] counter;
   logic             pending;
   logic             aligned;
   logic             timed_out;

   assign pending   = m2reg_mem | wmem_mem;
   assign aligned   = (Alu_Result_mem[1:0] == 2'b00);
   assign timed_out = (counter == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state <= IDLE;
      else         state <= next_state;
   end

   // DONE, EXC and ERR each last one cycle with stall released, so EX/MEM advances exactly once
   always_comb begin
      next_state = state;
      stall_pipe = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               stall_pipe = 1'b1;
               next_state = aligned ? ACCESS : EXC;
            end
         end
         ACCESS: begin
            stall_pipe = 1'b1;
            if (mem_ready)      next_state = DONE;
            else if (timed_out) next_state = ERR;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         counter      <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_wdata    <= 32'd0;
         load_data    <= 32'd0;
         load_valid   <= 1'b0;
         misalign_exc <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         load_valid   <= 1'b0;
         misalign_exc <= (next_state == EXC);
         bus_err      <= (next_state == ERR);
         case (state)
            IDLE: begin
               if (pending && aligned) begin
                  mem_req   <= 1'b1;
                  mem_we    <= wmem_mem;
                  mem_addr  <= {Alu_Result_mem[31:2], 2'b00};
                  mem_wdata <= rb_mem;
                  counter   <= '0;
               end
            end
            // mem_we still holds the access type, so it selects whether read data is captured
            ACCESS: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     load_data  <= mem_rdata;
                     load_valid <= 1'b1;
                  end
               end else if (timed_out) begin
                  mem_req <= 1'b0;
               end else begin
                  counter <= counter + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: a table of accesses run back-to-back against a simple
// variable-latency memory, plus a hand-written reset-during-access sequence.
module tb_mem_stage_ctrl;

   logic        Clock;
   logic        Resetn;
   logic        m2reg_mem;
   logic        wmem_mem;
   logic [31:0] Alu_Result_mem;
   logic [31:0] rb_mem;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        stall_pipe;
   logic [31:0] load_data;
   logic        load_valid;
   logic        misalign_exc;
   logic        bus_err;

   int total = 0;
   int bad   = 0;

   // wait_cycles: ACCESS cycles before mem_ready is given; -1 means memory never answers
   typedef struct {
      logic        ld;
      logic        st;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          wait_cycles;
      logic [31:0] rdata;
      logic        spurious;
      int          exp_stall;
      int          exp_req;
      logic        exp_we;
      logic        exp_lv;
      logic        exp_exc;
      logic        exp_err;
      logic [31:0] exp_ld;
   } vec_t;

   vec_t exp_q[$];
   vec_t vecs[9];

   mem_stage_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .Clock          (Clock),
      .Resetn         (Resetn),
      .m2reg_mem      (m2reg_mem),
      .wmem_mem       (wmem_mem),
      .Alu_Result_mem (Alu_Result_mem),
      .rb_mem         (rb_mem),
      .mem_ready      (mem_ready),
      .mem_rdata      (mem_rdata),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .stall_pipe     (stall_pipe),
      .load_data      (load_data),
      .load_valid     (load_valid),
      .misalign_exc   (misalign_exc),
      .bus_err        (bus_err)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      m2reg_mem      = v.ld;
      wmem_mem       = v.st;
      Alu_Result_mem = v.addr;
      rb_mem         = v.wdata;
      exp_q.push_back(v);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, ".mem_req"},      {31'd0, mem_req},      32'd0);
      checkOutput({tag, ".mem_we"},       {31'd0, mem_we},       32'd0);
      checkOutput({tag, ".mem_addr"},     mem_addr,              32'd0);
      checkOutput({tag, ".mem_wdata"},    mem_wdata,             32'd0);
      checkOutput({tag, ".load_data"},    load_data,             32'd0);
      checkOutput({tag, ".load_valid"},   {31'd0, load_valid},   32'd0);
      checkOutput({tag, ".misalign_exc"}, {31'd0, misalign_exc}, 32'd0);
      checkOutput({tag, ".bus_err"},      {31'd0, bus_err},      32'd0);
      checkOutput({tag, ".stall_pipe"},   {31'd0, stall_pipe},   32'd0);
   endtask

   // Called just after a rising edge; returns just after the edge that ends DONE/EXC/ERR.
   task automatic runTxn(input string tag, input vec_t v);
      vec_t        e;
      int          stall_cnt = 0;
      int          req_cnt   = 0;
      logic        hold_bad  = 1'b0;
      logic        stray     = 1'b0;
      logic        finished  = 1'b0;
      logic        lv        = 1'b0;
      logic        exc       = 1'b0;
      logic        err       = 1'b0;
      logic [31:0] ld        = 32'd0;
      applyStimulus(v);
      for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
         @(negedge Clock);
         if (stall_pipe) begin
            stall_cnt++;
            if (load_valid || misalign_exc || bus_err) stray = 1'b1;
         end
         if (mem_req) begin
            req_cnt++;
            if (mem_addr !== v.addr || mem_we !== v.exp_we || mem_wdata !== v.wdata) hold_bad = 1'b1;
            mem_ready = (v.wait_cycles >= 0) && (req_cnt == v.wait_cycles + 1);
            mem_rdata = mem_ready ? v.rdata : 32'hBAD0BAD0;
         end else begin
            mem_ready = v.spurious;
            mem_rdata = 32'hBAD0BAD0;
         end
         if (!stall_pipe && stall_cnt > 0) begin
            finished = 1'b1;
            lv  = load_valid;
            exc = misalign_exc;
            err = bus_err;
            ld  = load_data;
         end
         @(posedge Clock);
         #1;
      end
      m2reg_mem = 1'b0;
      wmem_mem  = 1'b0;
      mem_ready = 1'b0;
      e = exp_q.pop_front();
      checkOutput({tag, ".completed"},    {31'd0, finished},  32'd1);
      checkOutput({tag, ".stall_cycles"}, 32'(stall_cnt),     32'(e.exp_stall));
      checkOutput({tag, ".req_cycles"},   32'(req_cnt),       32'(e.exp_req));
      checkOutput({tag, ".req_fields"},   {31'd0, hold_bad},  32'd0);
      checkOutput({tag, ".stray_pulse"},  {31'd0, stray},     32'd0);
      checkOutput({tag, ".load_valid"},   {31'd0, lv},        {31'd0, e.exp_lv});
      checkOutput({tag, ".misalign_exc"}, {31'd0, exc},       {31'd0, e.exp_exc});
      checkOutput({tag, ".bus_err"},      {31'd0, err},       {31'd0, e.exp_err});
      checkOutput({tag, ".load_data"},    ld,                 e.exp_ld);
   endtask

   initial begin
      vec_t v;
      //           ld    st    addr          wdata         wait rdata         spur  stall req we    lv    exc   err   load_data
      vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0, 2,  1,  1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 3, 32'h0000_0000, 1'b0, 5,  4,  1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0103, 32'h0000_0000, 0, 32'h5555_5555, 1'b0, 1,  0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, -1, 32'h0000_0000, 1'b0, 17, 16, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
      vecs[4] = '{1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 1, 32'h6666_6666, 1'b0, 3,  2,  1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 0, 32'h1111_1111, 1'b0, 2,  1,  1'b0, 1'b1, 1'b0, 1'b0, 32'h1111_1111};
      vecs[6] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000, 0, 32'h2222_2222, 1'b1, 2,  1,  1'b0, 1'b1, 1'b0, 1'b0, 32'h2222_2222};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 15, 32'h3333_3333, 1'b0, 17, 16, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3333_3333};
      vecs[8] = '{1'b0, 1'b1, 32'h0000_0202, 32'h7777_7777, 0, 32'h0000_0000, 1'b0, 1,  0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h3333_3333};

      Resetn         = 1'b0;
      m2reg_mem      = 1'b0;
      wmem_mem       = 1'b0;
      Alu_Result_mem = 32'd0;
      rb_mem         = 32'd0;
      mem_ready      = 1'b0;
      mem_rdata      = 32'd0;
      repeat (3) @(negedge Clock);
      Resetn = 1'b1;
      @(posedge Clock);
      #1;
      checkIdleOutputs("reset");

      for (int i = 0; i < 9; i++) begin
         $display("[TB] vector %0d addr=0x%08h", i, vecs[i].addr);
         runTxn($sformatf("vec%0d", i), vecs[i]);
      end

      // Reset pulled in the second ACCESS cycle of a load must drop mem_req without a clock
      m2reg_mem      = 1'b1;
      Alu_Result_mem = 32'h0000_0500;
      rb_mem         = 32'd0;
      @(posedge Clock);
      #1;
      @(negedge Clock);
      checkOutput("rst_mid.req_first_access", {31'd0, mem_req}, 32'd1);
      @(posedge Clock);
      #2;
      Resetn = 1'b0;
      #1;
      checkOutput("rst_mid.req_dropped", {31'd0, mem_req}, 32'd0);
      m2reg_mem      = 1'b0;
      Alu_Result_mem = 32'd0;
      @(negedge Clock);
      @(negedge Clock);
      Resetn = 1'b1;
      @(posedge Clock);
      #1;
      checkIdleOutputs("rst_mid.after");

      v = '{1'b1, 1'b0, 32'h0000_0060, 32'h0000_0000, 0, 32'h4444_4444, 1'b0, 2, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4444_4444};
      runTxn("post_reset_load", v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
